// File: rtl/rtc_bcd_serial.sv
// Serial BCD real-time clock (uPD4990-class): 4-bit command + 48-bit time shift register,
// calendar counter and TP pulse generator. Define RTC_TEST_MODE_EN to enable command F (test mode).
`timescale 1ns / 1ps

module rtc_bcd_serial #(
    parameter int unsigned TICK_DIV      = 8,
    parameter logic [47:0] INIT_TIME     = 48'h892424113000,
    parameter logic [3:0]  TP_RESET_MODE = 4'h4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic CS,
    input  logic OE,
    input  logic SER_CLK,
    input  logic DATA_IN,
    input  logic STROBE,
    output logic DATA_OUT,
    output logic TP
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic {OutHold, OutShift} out_mode_e;

    logic [2:0]    ser_clk_sync_q, strobe_sync_q;
    logic [1:0]    data_sync_q;
    logic          ser_edge, strobe_edge;
    logic [51:0]   sr_q, sr_d, sr_shift;
    logic [3:0]    cmd;
    logic [47:0]   time_q, time_d;
    logic [11:0]   sub_q, sub_d;
    logic [PW-1:0] presc_q, presc_d;
    out_mode_e     out_mode_q, out_mode_d;
    logic [3:0]    tp_mode_q, tp_mode_d;
    logic          ivl_run_q, ivl_run_d;
    logic [5:0]    ivl_cnt_q, ivl_cnt_d, ivl_half;
    logic          ivl_tp_q, ivl_tp_d;
    logic          tp_d, data_out_d;
    logic          tick, sec_carry, half_evt;
`ifdef RTC_TEST_MODE_EN
    logic          test_mode_q, test_mode_d;
`endif

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
        else                r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] month_last(input logic [3:0] mon, input logic [7:0] yr);
        logic [4:0] m4;
        logic [7:0] r;
        // tens*10 = tens*2 (mod 4), so this sum has the same residue mod 4 as the year value
        m4 = {yr[7:4], 1'b0} + {1'b0, yr[3:0]};
        case (mon)
            4'd2:                     r = (m4[1:0] == 2'd0) ? 8'h29 : 8'h28;
            4'd4, 4'd6, 4'd9, 4'd11: r = 8'h30;
            default:                  r = 8'h31;
        endcase
        return r;
    endfunction

    function automatic logic [47:0] next_time(input logic [47:0] cur);
        logic [47:0] t;
        t = cur;
        if (t[7:0] != 8'h59) t[7:0] = bcd_inc(t[7:0]);
        else begin
            t[7:0] = 8'h00;
            if (t[15:8] != 8'h59) t[15:8] = bcd_inc(t[15:8]);
            else begin
                t[15:8] = 8'h00;
                if (t[23:16] != 8'h23) t[23:16] = bcd_inc(t[23:16]);
                else begin
                    t[23:16] = 8'h00;
                    t[35:32] = (t[35:32] == 4'd6) ? 4'd0 : t[35:32] + 4'd1;
                    if (t[31:24] != month_last(t[39:36], t[47:40])) begin
                        t[31:24] = bcd_inc(t[31:24]);
                    end else begin
                        t[31:24] = 8'h01;
                        if (t[39:36] != 4'd12) t[39:36] = t[39:36] + 4'd1;
                        else begin
                            t[39:36] = 4'd1;
                            t[47:40] = (t[47:40] == 8'h99) ? 8'h00 : bcd_inc(t[47:40]);
                        end
                    end
                end
            end
        end
        return t;
    endfunction

    assign ser_edge    = CS & ser_clk_sync_q[1] & ~ser_clk_sync_q[2];
    assign strobe_edge = CS & strobe_sync_q[1] & ~strobe_sync_q[2];
    assign sr_shift    = ser_edge ? {data_sync_q[1], sr_q[51:1]} : sr_q;
    assign cmd         = sr_shift[51:48];
    assign tick        = (presc_q == PRESC_MAX);
    assign half_evt    = tick && (sub_q[10:0] == 11'h7FF);
`ifdef RTC_TEST_MODE_EN
    assign sec_carry   = tick && (test_mode_q || (sub_q == 12'hFFF));
`else
    assign sec_carry   = tick && (sub_q == 12'hFFF);
`endif

    // Interval half period in half-second units (period 1/10/30/60 s)
    always_comb begin
        ivl_half = 6'd1;
        case (tp_mode_q[1:0])
            2'd0: ivl_half = 6'd1;
            2'd1: ivl_half = 6'd10;
            2'd2: ivl_half = 6'd30;
            2'd3: ivl_half = 6'd60;
        endcase
    end

    always_comb begin
        sr_d       = sr_shift;
        time_d     = time_q;
        sub_d      = sub_q;
        presc_d    = tick ? '0 : presc_q + PW'(1);
        out_mode_d = out_mode_q;
        tp_mode_d  = tp_mode_q;
        ivl_run_d  = ivl_run_q;
        ivl_cnt_d  = ivl_cnt_q;
        ivl_tp_d   = ivl_tp_q;
`ifdef RTC_TEST_MODE_EN
        test_mode_d = test_mode_q;
`endif

        if (tick) sub_d = sub_q + 12'd1;
        if (sec_carry) time_d = next_time(time_q);

        if (tp_mode_q[3] && ivl_run_q && half_evt) begin
            if (ivl_cnt_q == ivl_half - 6'd1) begin
                ivl_cnt_d = '0;
                ivl_tp_d  = ~ivl_tp_q;
            end else begin
                ivl_cnt_d = ivl_cnt_q + 6'd1;
            end
        end

        // Decode comes last so a time set overrides a coincident second carry
        if (strobe_edge) begin
            case (cmd)
                4'h0: out_mode_d = OutHold;
                4'h1: out_mode_d = OutShift;
                4'h2: begin
                    time_d    = sr_shift[47:0];
                    sub_d     = '0;
                    presc_d   = '0;
                    ivl_cnt_d = '0;
                end
                4'h3: begin
                    sr_d       = {sr_shift[51:48], time_q};
                    out_mode_d = OutShift;
                end
                4'h4, 4'h5, 4'h6, 4'h7: tp_mode_d = cmd;
                4'h8, 4'h9, 4'hA, 4'hB: begin
                    tp_mode_d = cmd;
                    ivl_cnt_d = '0;
                    ivl_tp_d  = 1'b0;
                end
                4'hC: ivl_cnt_d = '0;
                4'hD: ivl_run_d = 1'b1;
                4'hE: ivl_run_d = 1'b0;
                4'hF: ;
            endcase
`ifdef RTC_TEST_MODE_EN
            if (cmd == 4'hF)             test_mode_d = 1'b1;
            else if (cmd[3:2] == 2'b00)  test_mode_d = 1'b0;
`endif
        end
    end

    always_comb begin
        tp_d = ivl_tp_q;
        case (tp_mode_q)
            4'h4:    tp_d = sub_q[5];
            4'h5:    tp_d = sub_q[3];
            4'h6:    tp_d = sub_q[0];
            4'h7:    tp_d = sub_q[11];
            default: tp_d = ivl_tp_q;
        endcase
        data_out_d = 1'b1;
        if (OE) data_out_d = (out_mode_q == OutShift) ? sr_q[0] : sub_q[11];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ser_clk_sync_q <= '0;
            strobe_sync_q  <= '0;
            data_sync_q    <= '0;
            sr_q           <= {4'h0, INIT_TIME};
            time_q         <= INIT_TIME;
            sub_q          <= '0;
            presc_q        <= '0;
            out_mode_q     <= OutHold;
            tp_mode_q      <= TP_RESET_MODE;
            ivl_run_q      <= 1'b1;
            ivl_cnt_q      <= '0;
            ivl_tp_q       <= 1'b0;
            TP             <= 1'b0;
            DATA_OUT       <= 1'b1;
`ifdef RTC_TEST_MODE_EN
            test_mode_q    <= 1'b0;
`endif
        end else begin
            ser_clk_sync_q <= {ser_clk_sync_q[1:0], SER_CLK};
            strobe_sync_q  <= {strobe_sync_q[1:0], STROBE};
            data_sync_q    <= {data_sync_q[0], DATA_IN};
            sr_q           <= sr_d;
            time_q         <= time_d;
            sub_q          <= sub_d;
            presc_q        <= presc_d;
            out_mode_q     <= out_mode_d;
            tp_mode_q      <= tp_mode_d;
            ivl_run_q      <= ivl_run_d;
            ivl_cnt_q      <= ivl_cnt_d;
            ivl_tp_q       <= ivl_tp_d;
            TP             <= tp_d;
            DATA_OUT       <= data_out_d;
`ifdef RTC_TEST_MODE_EN
            test_mode_q    <= test_mode_d;
`endif
        end
    end

endmodule

// File: tb/tb_rtc_bcd_serial.sv
// Directed self-checking bench for rtc_bcd_serial (TICK_DIV=2, so one second = 8192 CLK).
`timescale 1ns / 1ps

module tb_rtc_bcd_serial;

    logic CLK = 1'b0;
    logic RESET, CS, OE, SER_CLK, DATA_IN, STROBE;
    logic DATA_OUT, TP;
    int   n_checks = 0;
    int   n_errors = 0;

    rtc_bcd_serial #(.TICK_DIV(2)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .CS       (CS),
        .OE       (OE),
        .SER_CLK  (SER_CLK),
        .DATA_IN  (DATA_IN),
        .STROBE   (STROBE),
        .DATA_OUT (DATA_OUT),
        .TP       (TP)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic ser_bit(input logic b);
        DATA_IN = b;
        @(negedge CLK);
        SER_CLK = 1'b1;
        repeat (4) @(negedge CLK);
        SER_CLK = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic send_bits(input logic [51:0] v, input int n);
        for (int i = 0; i < n; i++) ser_bit(v[i]);
    endtask

    task automatic strobe_pulse();
        @(negedge CLK);
        STROBE = 1'b1;
        repeat (4) @(negedge CLK);
        STROBE = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic send_cmd(input logic [3:0] c);
        send_bits({48'h0, c}, 4);
        strobe_pulse();
    endtask

    task automatic set_time(input logic [47:0] t);
        send_bits({4'h2, t}, 52);
        strobe_pulse();
    endtask

    task automatic read_time(output logic [47:0] t);
        send_cmd(4'h3);
        for (int i = 0; i < 48; i++) begin
            t[i] = DATA_OUT;
            ser_bit(1'b0);
        end
    endtask

    // Cycles until TP changes from its current level, capped at max
    task automatic tp_run(input int max, output int len);
        logic prev;
        prev = TP;
        len  = 0;
        while (TP == prev && len < max) begin
            @(negedge CLK);
            len++;
        end
    endtask

    initial begin
        logic [47:0] t;
        logic [51:0] v;
        int len, len2;

        RESET = 1'b1; CS = 1'b1; OE = 1'b1;
        SER_CLK = 1'b0; DATA_IN = 1'b0; STROBE = 1'b0;
        repeat (4) @(negedge CLK);
        check("rst_tp", 48'(TP), 48'd0);
        check("rst_dout", 48'(DATA_OUT), 48'd1);
        RESET = 1'b0;

        // 64 Hz TP out of reset: high for 32 ticks
        tp_run(200, len);
        tp_run(200, len);
        check("tp64_high", 48'(len), 48'd64);

        // Hold mode: DATA_OUT follows SUB[11], forced high while OE low
        OE = 1'b0;
        repeat (2) @(negedge CLK);
        check("oe_low", 48'(DATA_OUT), 48'd1);
        OE = 1'b1;
        repeat (2) @(negedge CLK);
        check("hold_1hz_lo", 48'(DATA_OUT), 48'd0);
        repeat (4096) @(negedge CLK);
        check("hold_1hz_hi", 48'(DATA_OUT), 48'd1);
        repeat (4000) @(negedge CLK);
        read_time(t);
        check("init_plus_1s", t, 48'h892424113001);

        // Calendar rollovers, one second after each set
        set_time(48'h99C631235959);
        repeat (8192) @(negedge CLK);
        read_time(t);
        check("year_wrap", t, 48'h001001000000);

        set_time(48'h002628235959);
        repeat (8192) @(negedge CLK);
        read_time(t);
        check("feb_leap00", t, 48'h002029000000);

        set_time(48'h012628235959);
        repeat (8192) @(negedge CLK);
        read_time(t);
        check("feb_nonleap", t, 48'h013001000000);

        // Set, immediate read, strobe ignored with CS low, then BCD digit carry
        set_time(48'h245315123409);
        read_time(t);
        check("set_readback", t, 48'h245315123409);
        send_bits({4'h2, 48'h111111111111}, 52);
        CS = 1'b0;
        strobe_pulse();
        CS = 1'b1;
        read_time(t);
        check("cs_low_strobe", t, 48'h245315123409);
        repeat (8192) @(negedge CLK);
        read_time(t);
        check("sec_digit_carry", t, 48'h245315123410);

        // Last serial edge and strobe edge together: decode must see the post-shift nibble
        v = {4'h2, 48'h135208091011};
        send_bits(v, 51);
        DATA_IN = v[51];
        @(negedge CLK);
        SER_CLK = 1'b1;
        STROBE  = 1'b1;
        repeat (4) @(negedge CLK);
        SER_CLK = 1'b0;
        STROBE  = 1'b0;
        repeat (4) @(negedge CLK);
        read_time(t);
        check("same_cycle_set", t, 48'h135208091011);

        // 256 Hz: 16 ticks period, 50% duty
        send_cmd(4'h5);
        tp_run(100, len);
        tp_run(100, len);
        tp_run(100, len2);
        check("tp256_half_a", 48'(len), 48'd16);
        check("tp256_half_b", 48'(len2), 48'd16);

        send_cmd(4'h6);
        tp_run(100, len);
        tp_run(100, len);
        check("tp2048_half", 48'(len), 48'd2);

        // Interval 1 s period: toggles every half second
        send_cmd(4'h8);
        tp_run(9000, len);
        tp_run(9000, len);
        check("ivl1s_half", 48'(len), 48'd4096);

        send_cmd(4'hE);
        tp_run(5000, len);
        check("ivl_stop_frozen", 48'(len), 48'd5000);
        send_cmd(4'hD);
        tp_run(5000, len);
        check("ivl_run_resumes", 48'(len < 5000), 48'd1);

        // Command F
        set_time(48'h135208091000);
        send_cmd(4'hF);
        repeat (2000) @(negedge CLK);
        read_time(t);
`ifdef RTC_TEST_MODE_EN
        check("cmdF_fast", 48'(t != 48'h135208091000), 48'd1);
`else
        check("cmdF_noop", t, 48'h135208091000);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
